// File: rtl/sig_mmio_sink_if.sv
// Store-bus and drain-stream signals for sig_mmio_sink.
// The master modport belongs to the pipeline/downstream side and the slave modport to the sink.
interface sig_mmio_sink_if;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        wr;
   logic        out_ready;
   logic        out_valid;
   logic [31:0] out_data;

   modport master (
      output addr, wdata, wr, out_ready,
      input  out_valid, out_data
   );

   modport slave (
      input  addr, wdata, wr, out_ready,
      output out_valid, out_data
   );
endinterface

// File: rtl/sig_mmio_sink.sv
// Signature-capture store responder: stores to SIG_ADDR are queued and streamed out, and a store to HALT_ADDR raises halt once the queue drains.
// Defining SIG_CYCLE_TIMEOUT_EN adds a cycle watchdog that forces halt and timeout.
module sig_mmio_sink #(
   parameter logic [31:0] SIG_ADDR   = 32'h00000F00,
   parameter logic [31:0] HALT_ADDR  = 32'hCAFEBEEF,
   parameter int unsigned DEPTH      = 16,
   parameter int unsigned MAX_CYCLES = 500
) (
   input  logic                   clk,
   input  logic                   rst,
   sig_mmio_sink_if.slave         bus,
   output logic [$clog2(DEPTH):0] count,
   output logic                   overflow,
   output logic                   halt,
   output logic                   timeout
);
   localparam int unsigned AW = $clog2(DEPTH);

   typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_HALTED} state_e;

   state_e        state_q, state_d;
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   count_q, count_d;
   logic          overflow_q, overflow_d;
   logic          halt_q, halt_d;
   logic [31:0]   mem_q [DEPTH];

   logic sig_wr, halt_wr, accept, push, pop;

`ifdef SIG_CYCLE_TIMEOUT_EN
   logic [31:0] cyc_q, cyc_d;
   logic        timeout_q, timeout_d;
`endif

   always_comb begin
      sig_wr  = !bus.wr && (bus.addr == SIG_ADDR);
      halt_wr = !bus.wr && (bus.addr == HALT_ADDR);
      pop     = (count_q != '0) && bus.out_ready;
      accept  = sig_wr && (state_q != ST_HALTED);
      // A full queue still takes a word when its head leaves in the same cycle.
      push    = accept && ((count_q != (AW+1)'(DEPTH)) || pop);

      wr_ptr_d   = wr_ptr_q + AW'(push);
      rd_ptr_d   = rd_ptr_q + AW'(pop);
      count_d    = count_q + (AW+1)'(push) - (AW+1)'(pop);
      overflow_d = overflow_q | (accept & ~push);

      state_d = state_q;
      case (state_q)
         ST_RUN:    if (halt_wr) state_d = ST_DRAIN;
         ST_DRAIN:  if ((count_q == '0) && !push) state_d = ST_HALTED;
         ST_HALTED: state_d = ST_HALTED;
         default:   state_d = ST_RUN;
      endcase
      halt_d = halt_q | (state_d == ST_HALTED);

`ifdef SIG_CYCLE_TIMEOUT_EN
      timeout_d = timeout_q;
      cyc_d     = (state_q != ST_HALTED) ? cyc_q + 32'd1 : cyc_q;
      // Watchdog expiry overrides everything and empties the queue.
      if ((state_q != ST_HALTED) && (cyc_q == 32'(MAX_CYCLES - 1))) begin
         state_d   = ST_HALTED;
         halt_d    = 1'b1;
         timeout_d = 1'b1;
         count_d   = '0;
         wr_ptr_d  = '0;
         rd_ptr_d  = '0;
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_RUN;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
         halt_q     <= 1'b0;
`ifdef SIG_CYCLE_TIMEOUT_EN
         cyc_q      <= '0;
         timeout_q  <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
         halt_q     <= halt_d;
`ifdef SIG_CYCLE_TIMEOUT_EN
         cyc_q      <= cyc_d;
         timeout_q  <= timeout_d;
`endif
      end
   end

   // Storage needs no reset: out_data is masked to zero while the queue is empty.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= bus.wdata;
   end

   assign bus.out_valid = (count_q != '0);
   assign bus.out_data  = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
   assign count         = count_q;
   assign overflow      = overflow_q;
   assign halt          = halt_q;

`ifdef SIG_CYCLE_TIMEOUT_EN
   assign timeout = timeout_q;
`else
   logic unused_cfg;
   assign unused_cfg = (MAX_CYCLES != 0);
   assign timeout    = 1'b0;
`endif
endmodule

// File: tb/tb_sig_mmio_sink.sv
// Directed self-checking bench for sig_mmio_sink (DEPTH=16).
// The watchdog scenario runs only when SIG_CYCLE_TIMEOUT_EN is defined.
module tb_sig_mmio_sink;
   localparam logic [31:0] SIG  = 32'h00000F00;
   localparam logic [31:0] HLT  = 32'hCAFEBEEF;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [4:0] count;
   logic       overflow, halt, timeout;
   int         n_cmp = 0;
   int         n_err = 0;

   sig_mmio_sink_if bus ();

   sig_mmio_sink #(
      .SIG_ADDR   (SIG),
      .HALT_ADDR  (HLT),
      .DEPTH      (16),
      .MAX_CYCLES (500)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .bus      (bus.slave),
      .count    (count),
      .overflow (overflow),
      .halt     (halt),
      .timeout  (timeout)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL global_time_limit: got no finish, expected finish before limit");
      $fatal(1, "time limit");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   task automatic store(input logic [31:0] a, input logic [31:0] d);
      bus.wr    = 1'b0;
      bus.addr  = a;
      bus.wdata = d;
      tick();
      bus.wr    = 1'b1;
      bus.addr  = '0;
      bus.wdata = '0;
   endtask

   task automatic test_reset();
      bus.wr = 1'b1; bus.addr = '0; bus.wdata = '0; bus.out_ready = 1'b0;
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b expected 0", bus.out_valid); end
      n_cmp++; if (bus.out_data !== 32'h0) begin n_err++; $display("FAIL reset_data: got %h expected 0", bus.out_data); end
      n_cmp++; if (count !== 5'd0) begin n_err++; $display("FAIL reset_count: got %0d expected 0", count); end
      n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
      n_cmp++; if (halt !== 1'b0) begin n_err++; $display("FAIL reset_halt: got %b expected 0", halt); end
      n_cmp++; if (timeout !== 1'b0) begin n_err++; $display("FAIL reset_timeout: got %b expected 0", timeout); end
   endtask

   task automatic test_single();
      apply_reset();
      bus.out_ready = 1'b1;
      store(SIG, 32'hDEADBEEF);
      n_cmp++; if (bus.out_valid !== 1'b1) begin n_err++; $display("FAIL single_valid: got %b expected 1", bus.out_valid); end
      n_cmp++; if (bus.out_data !== 32'hDEADBEEF) begin n_err++; $display("FAIL single_data: got %h expected deadbeef", bus.out_data); end
      n_cmp++; if (count !== 5'd1) begin n_err++; $display("FAIL single_count: got %0d expected 1", count); end
      tick();
      n_cmp++; if (count !== 5'd0) begin n_err++; $display("FAIL single_popped_count: got %0d expected 0", count); end
      n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL single_popped_valid: got %b expected 0", bus.out_valid); end
   endtask

   task automatic test_overflow();
      apply_reset();
      bus.out_ready = 1'b0;
      for (int i = 1; i <= 16; i++) store(SIG, 32'(i));
      n_cmp++; if (count !== 5'd16) begin n_err++; $display("FAIL ovf_full_count: got %0d expected 16", count); end
      n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL ovf_not_yet: got %b expected 0", overflow); end
      store(SIG, 32'd17);
      n_cmp++; if (count !== 5'd16) begin n_err++; $display("FAIL ovf_count: got %0d expected 16", count); end
      n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_flag: got %b expected 1", overflow); end
      bus.out_ready = 1'b1;
      for (int i = 1; i <= 16; i++) begin
         n_cmp++;
         if (bus.out_valid !== 1'b1 || bus.out_data !== 32'(i)) begin
            n_err++; $display("FAIL ovf_drain_%0d: got valid=%b data=%h expected valid=1 data=%h", i, bus.out_valid, bus.out_data, 32'(i));
         end
         tick();
      end
      n_cmp++; if (bus.out_valid !== 1'b0 || count !== 5'd0) begin n_err++; $display("FAIL ovf_drained: got valid=%b count=%0d expected 0/0", bus.out_valid, count); end
      n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_sticky: got %b expected 1", overflow); end
   endtask

   task automatic test_full_pop();
      apply_reset();
      bus.out_ready = 1'b0;
      for (int i = 0; i < 16; i++) store(SIG, 32'h100 + 32'(i));
      bus.out_ready = 1'b1;
      store(SIG, 32'hA5);
      n_cmp++; if (count !== 5'd16) begin n_err++; $display("FAIL fullpop_count: got %0d expected 16", count); end
      n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL fullpop_overflow: got %b expected 0", overflow); end
      for (int i = 1; i < 16; i++) begin
         n_cmp++;
         if (bus.out_data !== 32'h100 + 32'(i)) begin
            n_err++; $display("FAIL fullpop_drain_%0d: got %h expected %h", i, bus.out_data, 32'h100 + 32'(i));
         end
         tick();
      end
      n_cmp++; if (bus.out_data !== 32'hA5 || bus.out_valid !== 1'b1) begin n_err++; $display("FAIL fullpop_last: got valid=%b data=%h expected 1/a5", bus.out_valid, bus.out_data); end
      tick();
      n_cmp++; if (count !== 5'd0) begin n_err++; $display("FAIL fullpop_empty: got %0d expected 0", count); end
   endtask

   task automatic test_halt_after_drain();
      apply_reset();
      bus.out_ready = 1'b0;
      store(SIG, 32'h11);
      store(SIG, 32'h22);
      store(SIG, 32'h33);
      store(HLT, 32'h1);
      tick();
      n_cmp++; if (halt !== 1'b0 || count !== 5'd3) begin n_err++; $display("FAIL halt_wait: got halt=%b count=%0d expected 0/3", halt, count); end
      bus.out_ready = 1'b1;
      tick();
      tick();
      tick();
      n_cmp++; if (halt !== 1'b0 || count !== 5'd0) begin n_err++; $display("FAIL halt_third_pop: got halt=%b count=%0d expected 0/0", halt, count); end
      tick();
      n_cmp++; if (halt !== 1'b1) begin n_err++; $display("FAIL halt_raised: got %b expected 1", halt); end
      store(SIG, 32'h77);
      n_cmp++; if (count !== 5'd0 || bus.out_valid !== 1'b0) begin n_err++; $display("FAIL halt_ignores_store: got count=%0d valid=%b expected 0/0", count, bus.out_valid); end
      n_cmp++; if (halt !== 1'b1 || overflow !== 1'b0) begin n_err++; $display("FAIL halt_sticky: got halt=%b ovf=%b expected 1/0", halt, overflow); end
   endtask

   task automatic test_halt_empty();
      apply_reset();
      bus.out_ready = 1'b0;
      store(HLT, 32'h0);
      n_cmp++; if (halt !== 1'b0) begin n_err++; $display("FAIL halt_empty_n: got %b expected 0", halt); end
      tick();
      n_cmp++; if (halt !== 1'b1) begin n_err++; $display("FAIL halt_empty_n1: got %b expected 1", halt); end
   endtask

   task automatic test_wrong_addr();
      apply_reset();
      bus.out_ready = 1'b1;
      bus.wr = 1'b1; bus.addr = SIG; bus.wdata = 32'h5;
      tick();
      n_cmp++; if (count !== 5'd0) begin n_err++; $display("FAIL nostore_count: got %0d expected 0", count); end
      store(32'h00000F04, 32'h6);
      n_cmp++; if (count !== 5'd0 || bus.out_valid !== 1'b0) begin n_err++; $display("FAIL wrongaddr_count: got count=%0d valid=%b expected 0/0", count, bus.out_valid); end
      bus.wr = 1'b1; bus.addr = HLT;
      tick();
      tick();
      bus.addr = '0;
      n_cmp++; if (halt !== 1'b0) begin n_err++; $display("FAIL wrongaddr_halt: got %b expected 0", halt); end
   endtask

   task automatic test_reset_mid_drain();
      apply_reset();
      bus.out_ready = 1'b0;
      for (int i = 0; i < 5; i++) store(SIG, 32'hC0 + 32'(i));
      store(HLT, 32'h0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      n_cmp++; if (count !== 5'd0 || bus.out_valid !== 1'b0 || bus.out_data !== 32'h0) begin n_err++; $display("FAIL middrain_fifo: got count=%0d valid=%b data=%h expected 0/0/0", count, bus.out_valid, bus.out_data); end
      n_cmp++; if (halt !== 1'b0 || overflow !== 1'b0 || timeout !== 1'b0) begin n_err++; $display("FAIL middrain_flags: got halt=%b ovf=%b to=%b expected 0/0/0", halt, overflow, timeout); end
      store(SIG, 32'h99);
      n_cmp++; if (count !== 5'd1 || bus.out_data !== 32'h99) begin n_err++; $display("FAIL middrain_restart: got count=%0d data=%h expected 1/99", count, bus.out_data); end
      tick();
      n_cmp++; if (halt !== 1'b0) begin n_err++; $display("FAIL middrain_state_run: got %b expected 0", halt); end
   endtask

`ifdef SIG_CYCLE_TIMEOUT_EN
   task automatic test_watchdog();
      apply_reset();
      bus.out_ready = 1'b0;
      store(SIG, 32'h42);
      repeat (498) tick();
      n_cmp++; if (halt !== 1'b0 || timeout !== 1'b0 || count !== 5'd1) begin n_err++; $display("FAIL wd_before: got halt=%b to=%b count=%0d expected 0/0/1", halt, timeout, count); end
      tick();
      n_cmp++; if (halt !== 1'b1 || timeout !== 1'b1) begin n_err++; $display("FAIL wd_fire: got halt=%b to=%b expected 1/1", halt, timeout); end
      n_cmp++; if (count !== 5'd0 || bus.out_valid !== 1'b0) begin n_err++; $display("FAIL wd_flush: got count=%0d valid=%b expected 0/0", count, bus.out_valid); end
   endtask
`else
   task automatic test_watchdog();
      apply_reset();
      bus.out_ready = 1'b0;
      repeat (600) tick();
      n_cmp++; if (halt !== 1'b0 || timeout !== 1'b0) begin n_err++; $display("FAIL no_watchdog: got halt=%b to=%b expected 0/0", halt, timeout); end
   endtask
`endif

   initial begin
      test_reset();
      test_single();
      test_overflow();
      test_full_pop();
      test_halt_after_drain();
      test_halt_empty();
      test_wrong_addr();
      test_reset_mid_drain();
      test_watchdog();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
